// File: rtl/ffcp_rx_reorder_buffer.sv
// FFCP receive reorder buffer: stores msg payloads into per-index slots and
// streams them out strictly in index order through a readclk/outclk pull port.
module ffcp_rx_reorder_buffer #(
    parameter int DATA_LEN    = 769,
    parameter int INDEX_LEN   = 6,
    parameter int TYPE_LEN    = 2,
    parameter int WINDOW_LEN  = 8,
    parameter int SLOT_STRIDE = 1024,
    parameter int RAM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 metadata_inclk,
    input  logic [TYPE_LEN-1:0]  in_type,
    input  logic [INDEX_LEN-1:0] in_index,
    input  logic                 inclk,
    input  logic [7:0]           in,
    input  logic                 in_done,
    output logic                 commit_clk,
    output logic [INDEX_LEN-1:0] commit_index,
    output logic                 commit_syn,
    output logic                 rdy,
    input  logic                 readclk,
    output logic                 outclk,
    output logic [7:0]           out,
    output logic                 out_done
);

    localparam int SLOT_W = $clog2(WINDOW_LEN);
    localparam int SO_W   = $clog2(SLOT_STRIDE);
    localparam int OFF_W  = SO_W + 1;
    localparam int ADDR_W = SLOT_W + SO_W;
    localparam int DEPTH  = WINDOW_LEN * SLOT_STRIDE;

    localparam logic [OFF_W-1:0]     LAST  = OFF_W'(DATA_LEN - 1);
    localparam logic [OFF_W-1:0]     FULL  = OFF_W'(DATA_LEN);
    localparam logic [INDEX_LEN-1:0] WIN   = INDEX_LEN'(WINDOW_LEN);
    localparam logic [TYPE_LEN-1:0]  T_SYN = '0;
    localparam logic [TYPE_LEN-1:0]  T_MSG = TYPE_LEN'(1);

    typedef enum logic [1:0] {IDLE, WRITE, DROP} wr_state_e;

    wr_state_e            state_q, state_d;
    logic [SLOT_W-1:0]    wr_slot_q, wr_slot_d;
    logic [INDEX_LEN-1:0] wr_index_q, wr_index_d;
    logic [OFF_W-1:0]     wr_offset_q, wr_offset_d;
    logic                 is_syn_q, is_syn_d;
    logic [WINDOW_LEN-1:0] valid_q, valid_d;
    logic [INDEX_LEN-1:0] rd_index_q, rd_index_d;
    logic [OFF_W-1:0]     rd_offset_q, rd_offset_d;
    logic                 commit_clk_q, commit_clk_d;
    logic                 commit_syn_q, commit_syn_d;
    logic [INDEX_LEN-1:0] commit_index_q, commit_index_d;
    logic [RAM_LATENCY-1:0] pv_q, pv_d;
    logic [RAM_LATENCY-1:0] pd_q, pd_d;
    logic [RAM_LATENCY-1:0][7:0] pb_q;

    logic [7:0] mem [DEPTH];

    logic                 syn_meta;
    logic                 msg_meta;
    logic [SLOT_W-1:0]    in_slot;
    logic [INDEX_LEN-1:0] in_diff;
    logic                 in_win;
    logic [SLOT_W-1:0]    rd_slot;
    logic                 rd_fire;
    logic                 rd_last;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [ADDR_W-1:0]    rd_addr;

    assign syn_meta = metadata_inclk && (in_type == T_SYN);
    assign msg_meta = metadata_inclk && (in_type == T_MSG);
    assign in_slot  = in_index[SLOT_W-1:0];
    assign in_diff  = in_index - rd_index_q;
    assign in_win   = in_diff < WIN;
    assign rd_slot  = rd_index_q[SLOT_W-1:0];

    assign rdy     = valid_q[rd_slot];
    assign rd_fire = readclk && rdy && !syn_meta;
    assign rd_last = rd_fire && (rd_offset_q == LAST);

    // Overlong packets stop writing at FULL so they never spill into the next slot.
    assign wr_en   = (state_q == WRITE) && inclk && !metadata_inclk
                     && (wr_offset_q != FULL);
    assign wr_addr = {wr_slot_q, wr_offset_q[SO_W-1:0]};
    assign rd_addr = {rd_slot, rd_offset_q[SO_W-1:0]};

    assign commit_clk   = commit_clk_q;
    assign commit_syn   = commit_syn_q;
    assign commit_index = commit_index_q;
    assign outclk       = pv_q[RAM_LATENCY-1];
    assign out_done     = pd_q[RAM_LATENCY-1];
    assign out          = outclk ? pb_q[RAM_LATENCY-1] : 8'h00;

    always_comb begin
        state_d        = state_q;
        wr_slot_d      = wr_slot_q;
        wr_index_d     = wr_index_q;
        wr_offset_d    = wr_offset_q;
        is_syn_d       = is_syn_q;
        valid_d        = valid_q;
        rd_index_d     = rd_index_q;
        rd_offset_d    = rd_offset_q;
        commit_clk_d   = 1'b0;
        commit_syn_d   = 1'b0;
        commit_index_d = commit_index_q;

        if (metadata_inclk) begin
            wr_slot_d   = in_slot;
            wr_index_d  = in_index;
            wr_offset_d = '0;
            is_syn_d    = 1'b0;
            if (msg_meta && in_win && !valid_q[in_slot]) begin
                state_d = WRITE;
            end else begin
                state_d = DROP;
            end
        end else begin
            unique case (state_q)
                WRITE: begin
                    if (in_done) begin
                        state_d = IDLE;
                        if (wr_offset_q == LAST) begin
                            valid_d[wr_slot_q] = 1'b1;
                            commit_clk_d       = !is_syn_q;
                            commit_syn_d       = is_syn_q;
                            commit_index_d     = wr_index_q;
                        end
                    end else if (wr_en) begin
                        wr_offset_d = wr_offset_q + 1'b1;
                    end
                end
                DROP: begin
                    if (in_done) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end

        if (rd_fire) begin
            rd_offset_d = rd_offset_q + 1'b1;
            if (rd_last) begin
                rd_offset_d      = '0;
                rd_index_d       = rd_index_q + 1'b1;
                valid_d[rd_slot] = 1'b0;
            end
        end

        // A syn restarts the whole receive stream and wins over any read-side clear.
        if (syn_meta) begin
            valid_d     = '0;
            rd_index_d  = '0;
            rd_offset_d = '0;
            state_d     = WRITE;
            wr_slot_d   = '0;
            wr_index_d  = '0;
            is_syn_d    = 1'b1;
        end
    end

    always_comb begin
        pv_d    = '0;
        pd_d    = '0;
        pv_d[0] = rd_fire;
        pd_d[0] = rd_last;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            pv_d[i] = pv_q[i-1] && !syn_meta;
            pd_d[i] = pd_q[i-1] && !syn_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            wr_slot_q      <= '0;
            wr_index_q     <= '0;
            wr_offset_q    <= '0;
            is_syn_q       <= 1'b0;
            valid_q        <= '0;
            rd_index_q     <= '0;
            rd_offset_q    <= '0;
            commit_clk_q   <= 1'b0;
            commit_syn_q   <= 1'b0;
            commit_index_q <= '0;
            pv_q           <= '0;
            pd_q           <= '0;
        end else begin
            state_q        <= state_d;
            wr_slot_q      <= wr_slot_d;
            wr_index_q     <= wr_index_d;
            wr_offset_q    <= wr_offset_d;
            is_syn_q       <= is_syn_d;
            valid_q        <= valid_d;
            rd_index_q     <= rd_index_d;
            rd_offset_q    <= rd_offset_d;
            commit_clk_q   <= commit_clk_d;
            commit_syn_q   <= commit_syn_d;
            commit_index_q <= commit_index_d;
            pv_q           <= pv_d;
            pd_q           <= pd_d;
        end
    end

    // Slot RAM and its read data pipe carry no reset; out is gated by outclk.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= in;
        end
        pb_q[0] <= mem[rd_addr];
        for (int i = 1; i < RAM_LATENCY; i++) begin
            pb_q[i] <= pb_q[i-1];
        end
    end

endmodule

// File: tb/tb_ffcp_rx_reorder_buffer.sv
// Directed bench for ffcp_rx_reorder_buffer: ordering, drops, truncation,
// syn flush and index wraparound.
module tb_ffcp_rx_reorder_buffer;

    localparam int DL = 769;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       metadata_inclk = 1'b0;
    logic [1:0] in_type = '0;
    logic [5:0] in_index = '0;
    logic       inclk = 1'b0;
    logic [7:0] din = '0;
    logic       in_done = 1'b0;
    logic       readclk = 1'b0;
    logic       commit_clk;
    logic [5:0] commit_index;
    logic       commit_syn;
    logic       rdy;
    logic       outclk;
    logic [7:0] dout;
    logic       out_done;

    ffcp_rx_reorder_buffer dut (
        .clk(clk), .rst(rst),
        .metadata_inclk(metadata_inclk), .in_type(in_type),
        .in_index(in_index), .inclk(inclk), .in(din),
        .in_done(in_done), .commit_clk(commit_clk),
        .commit_index(commit_index), .commit_syn(commit_syn),
        .rdy(rdy), .readclk(readclk), .outclk(outclk),
        .out(dout), .out_done(out_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ob[$];
    bit         od[$];
    int         oc[$];
    int         ci[$];
    int         cc[$];
    int         sn = 0;
    int         sc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (outclk) begin
                ob.push_back(dout);
                od.push_back(out_done);
                oc.push_back(cyc);
            end
            if (commit_clk) begin
                ci.push_back(int'(commit_index));
                cc.push_back(cyc);
            end
            if (commit_syn) begin
                sn++;
                sc = cyc;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int dcyc = 0;
    int rc = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pay(int key, int k);
        return 8'((key * 29 + k * 3 + 5) & 255);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bytes_only(int n, int key, bit with_done);
        for (int k = 0; k < n; k++) begin
            inclk   = 1'b1;
            din     = pay(key, k);
            in_done = with_done && (k == n - 1);
            if (in_done) dcyc = cyc;
            tick();
        end
        inclk   = 1'b0;
        in_done = 1'b0;
        din     = '0;
        tick();
        tick();
    endtask

    task automatic send(int typ, int idx, int n, int key, bit with_done);
        metadata_inclk = 1'b1;
        in_type        = 2'(typ);
        in_index       = 6'(idx);
        tick();
        metadata_inclk = 1'b0;
        bytes_only(n, key, with_done);
    endtask

    task automatic msg(int idx, int key);
        send(1, idx, DL, key, 1'b1);
    endtask

    task automatic exp_commit(string tag, int idx);
        check({tag, "_n"}, ci.size(), 1);
        if (ci.size() > 0) begin
            check({tag, "_idx"}, ci[0], idx);
            check({tag, "_lat"}, cc[0] - dcyc, 1);
        end
        ci.delete();
        cc.delete();
    endtask

    task automatic drain(string tag, int n);
        int target;
        target  = ob.size() + n;
        readclk = 1'b1;
        rc      = cyc;
        for (int i = 0; i < n + 64; i++) begin
            tick();
            if (ob.size() >= target) break;
        end
        readclk = 1'b0;
        repeat (4) tick();
        check({tag, "_cnt"}, ob.size(), target);
    endtask

    task automatic expect_pkt(string tag, int key);
        int bad;
        int dbad;
        logic [7:0] b;
        bit d;
        bad  = 0;
        dbad = 0;
        if (ob.size() < DL) begin
            check({tag, "_avail"}, ob.size(), DL);
            return;
        end
        for (int k = 0; k < DL; k++) begin
            b = ob.pop_front();
            d = od.pop_front();
            void'(oc.pop_front());
            if (b !== pay(key, k)) bad++;
            if (d !== (k == DL - 1)) dbad++;
        end
        check({tag, "_data"}, bad, 0);
        check({tag, "_done"}, dbad, 0);
    endtask

    initial begin
        int n_at;
        int bad;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_rdy", rdy, 0);
        check("rst_outclk", outclk, 0);
        check("rst_out", dout, 0);
        check("rst_out_done", out_done, 0);
        check("rst_commit_clk", commit_clk, 0);
        check("rst_commit_syn", commit_syn, 0);
        check("rst_commit_index", commit_index, 0);

        // initial syn occupies index 0
        send(0, 0, DL, 100, 1'b1);
        check("syn0_n", sn, 1);
        check("syn0_lat", sc - dcyc, 1);
        check("syn0_nomsg", ci.size(), 0);
        check("syn0_rdy", rdy, 1);
        drain("syn0", DL);
        expect_pkt("syn0", 100);
        check("syn0_rdy_after", rdy, 0);

        // in-order delivery
        msg(1, 1); exp_commit("t1_c1", 1);
        msg(2, 2); exp_commit("t1_c2", 2);
        msg(3, 3); exp_commit("t1_c3", 3);
        drain("t1", 3 * DL);
        if (ob.size() >= 3 * DL) begin
            check("t1_first_lat", oc[0] - rc, 2);
            check("t1_contig", oc[3*DL-1] - oc[0], 3 * DL - 1);
        end
        expect_pkt("t1_p1", 1);
        expect_pkt("t1_p2", 2);
        expect_pkt("t1_p3", 3);

        // reordering: rd_index=4, arrival 6,4,5
        msg(6, 6); exp_commit("t2_c6", 6);
        check("t2_rdy_wait", rdy, 0);
        msg(4, 4); exp_commit("t2_c4", 4);
        check("t2_rdy_go", rdy, 1);
        msg(5, 5); exp_commit("t2_c5", 5);
        drain("t2", 3 * DL);
        expect_pkt("t2_p4", 4);
        expect_pkt("t2_p5", 5);
        expect_pkt("t2_p6", 6);

        // duplicate, out of window, ack: rd_index=7
        msg(8, 8); exp_commit("t3_c8", 8);
        msg(8, 99);
        check("t3_dup", ci.size(), 0);
        msg(15, 15);
        check("t3_oow", ci.size(), 0);
        send(2, 7, DL, 98, 1'b1);
        check("t3_ack", ci.size(), 0);
        check("t3_rdy", rdy, 0);
        readclk = 1'b1;
        repeat (6) tick();
        readclk = 1'b0;
        repeat (3) tick();
        check("t3_noread", ob.size(), 0);
        msg(7, 7); exp_commit("t3_c7", 7);
        drain("t3", 2 * DL);
        expect_pkt("t3_p7", 7);
        expect_pkt("t3_p8", 8);

        // truncation: rd_index=9
        send(1, 9, 100, 9, 1'b0);
        msg(10, 10); exp_commit("t4_c10", 10);
        check("t4_rdy", rdy, 0);
        msg(9, 9); exp_commit("t4_c9", 9);
        drain("t4", 2 * DL);
        expect_pkt("t4_p9", 9);
        expect_pkt("t4_p10", 10);
        send(1, 11, 50, 11, 1'b1);
        check("t4_short", ci.size(), 0);
        check("t4_short_rdy", rdy, 0);
        msg(11, 11); exp_commit("t4_c11", 11);
        drain("t4b", DL);
        expect_pkt("t4_p11", 11);

        // syn in the middle of a read
        msg(12, 12); exp_commit("t5_c12", 12);
        readclk = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (ob.size() >= 300) break;
        end
        check("t5_pre", ob.size(), 300);
        metadata_inclk = 1'b1;
        in_type        = 2'd0;
        in_index       = 6'd0;
        tick();
        metadata_inclk = 1'b0;
        readclk        = 1'b0;
        n_at           = ob.size();
        check("t5_at_syn", n_at, 301);
        bytes_only(DL, 200, 1'b1);
        check("t5_flushed", ob.size(), n_at);
        check("t5_syn_n", sn, 2);
        check("t5_syn_lat", sc - dcyc, 1);
        bad = 0;
        for (int k = 0; k < ob.size(); k++) begin
            if (ob[k] !== pay(12, k)) bad++;
        end
        check("t5_prefix", bad, 0);
        ob.delete();
        od.delete();
        oc.delete();
        drain("t5", DL);
        expect_pkt("t5_syn", 200);
        check("t5_rdy_after", rdy, 0);

        // wraparound: syn as index 0, then msgs 1..70
        send(0, 0, DL, 0, 1'b1);
        check("t6_syn_n", sn, 3);
        readclk = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            msg(i % 64, i);
            exp_commit($sformatf("t6_c%0d", i), i % 64);
        end
        for (int i = 0; i < 3 * DL; i++) begin
            if (ob.size() >= 71 * DL) break;
            tick();
        end
        readclk = 1'b0;
        repeat (4) tick();
        check("t6_cnt", ob.size(), 71 * DL);
        for (int i = 0; i <= 70; i++) begin
            expect_pkt($sformatf("t6_p%0d", i), i);
        end
        check("t6_rdy_end", rdy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ffcp_rx_reorder_buffer.md
Name: ffcp_rx_reorder_buffer

Overview:
- Sits directly downstream of ffcp_rx and alongside ffcp_rx_server.
- Stores FFCP msg payloads into per-index slots of a byte RAM and reports completed packets to ffcp_rx_server as inclk/in_index/syn.
- Streams payloads out strictly in index order to the FGP consumer through a readclk/outclk pull interface.
- Absorbs out-of-order arrival and duplicate retransmits within the receive window.

Parameters:
DATA_LEN, 769, payload bytes per FFCP packet (FFCP_DATA_LEN)
INDEX_LEN, 6, FFCP index width
TYPE_LEN, 2, FFCP type width
WINDOW_LEN, 8, receive window and slot count; power of 2, at most 2**(INDEX_LEN-1)
SLOT_STRIDE, 1024, RAM address stride per slot; power of 2, at least DATA_LEN
RAM_LATENCY, 2, read latency of the slot RAM in clk cycles

Ports:
clk  in  1  clock
rst  in  1  reset
metadata_inclk  in  1  pulse; in_type/in_index valid (ffcp_rx metadata_outclk)
in_type  in  TYPE_LEN  0=syn, 1=msg, 2=ack
in_index  in  INDEX_LEN  packet index
inclk  in  1  payload byte strobe (ffcp_rx outclk)
in  in  8  payload byte
in_done  in  1  last payload byte strobe (ffcp_rx done; coincides with inclk)
commit_clk  out  1  pulse; msg packet fully stored
commit_index  out  INDEX_LEN  index of the committed packet
commit_syn  out  1  pulse; syn packet fully stored (drives ffcp_rx_server syn)
rdy  out  1  head packet available
readclk  in  1  consumer byte request
outclk  out  1  output byte strobe
out  out  8  output byte
out_done  out  1  coincides with outclk of the last byte of each packet

Behaviour:
- Reset is synchronous, active-high, on rst; clock clk. Reset state:
  - All outputs 0.
  - rd_index=0, rd_offset=0, every valid[] bit=0.
  - Write FSM in IDLE.
  - Read delay pipeline flushed.
- Slot of index i is i mod WINDOW_LEN. RAM address = slot*SLOT_STRIDE + offset. Index arithmetic is mod 2**INDEX_LEN.
- Write FSM states: IDLE, WRITE, DROP.
- On metadata_inclk, from any state (an unfinished packet is abandoned and not committed):
  - syn: same cycle, clear all valid[], set rd_index=0, set rd_offset=0, flush the read pipeline. Go to WRITE on slot 0 with is_syn=1.
  - msg, with (in_index - rd_index) < WINDOW_LEN and valid[slot]=0: go to WRITE on that slot with is_syn=0.
  - msg out of window, msg whose slot is already valid (duplicate), or ack: go to DROP.
- In WRITE, each inclk writes `in` at slot*SLOT_STRIDE + wr_offset, then wr_offset++.
- in_done in WRITE (the last byte is written that cycle):
  - Next cycle: set valid[slot]=1 and return to IDLE.
  - Also next cycle, a one-cycle pulse: commit_syn for a syn packet, or commit_clk with commit_index = packet index for a msg.
  - If in_done arrives with wr_offset != DATA_LEN-1, no commit and no pulse.
- In DROP: bytes are discarded and in_done returns to IDLE with no pulse. inclk in IDLE is ignored.
- rdy = valid[rd_index mod WINDOW_LEN], combinational.
- Read side:
  - readclk while rdy issues a RAM read of rd_offset.
  - outclk/out appear exactly RAM_LATENCY cycles later.
  - readclk while !rdy is ignored; it produces no outclk.
- On the read of byte DATA_LEN-1:
  - Same edge: valid[slot] cleared, rd_index++, rd_offset=0.
  - out_done is asserted with that byte's outclk.
- A commit and a read-side clear in the same cycle hit different slots; both take effect.
- A syn metadata in the same cycle as a read-side clear: the syn wins and all valid[] end 0.
- Throughput: one byte/cycle on both sides simultaneously. The RAM is simple dual-port (one write port, one read port).
- rst mid-packet drops the partial packet and any pipelined output bytes.

Test Plan:
- In-order delivery: msgs index 1, 2, 3 arrive in order, then readclk held high -> commit_clk at indices 1, 2, 3 each 1 cycle after in_done; 3*769 contiguous outclk bytes; out_done on bytes 769, 1538, 2307; first outclk 2 cycles after the first readclk.
- Reordering: msgs arrive 3, 1, 2 -> rdy stays 0 until 1 commits; output order is 1, 2, 3 by payload content.
- Duplicate and out-of-window: msg 2 sent twice before it is read -> one commit only. msg index 9 with rd_index=1 (diff 8) -> dropped, no commit. ack -> no commit.
- Truncation: msg 4 metadata, 100 bytes, then new msg 5 metadata and a full packet -> only commit_index=5. Slot 4 stays invalid and rdy stays 0 while rd_index=4.
- Syn mid-read: after 300 bytes of packet 1 are read, a syn with payload arrives -> outclk stops within 0 cycles after the flush. commit_syn pulses 1 cycle after syn in_done. Reading then returns the syn payload from slot 0.
- Wraparound: run indices 0..70 in order, through mod-64 index wrap -> every packet is committed and delivered. Index 63 is followed by index 0 with no drop.
